puf_sequencer: RTL

PUF_SEQUENCER -- requirements
Module: puf_sequencer

---
 rtl/puf_sequencer_if.sv | 27 ++
 rtl/puf_sequencer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/puf_sequencer_if.sv
// Handshake bundle between the PUF sequencer and its challenge source /
// ring-oscillator measurement controller.
interface puf_sequencer_if #(
  parameter int unsigned NBITS = 8
);
  logic             start;
  logic [7:0]       challenge;
  logic [1:0]       counter_ctrl_state;
  logic [31:0]      cnt_a;
  logic [31:0]      cnt_b;
  logic             roen;
  logic [7:0]       ro_pair;
  logic             busy;
  logic [NBITS-1:0] resp;
  logic             resp_valid;
  logic             err;

  modport master (
    output start, challenge, counter_ctrl_state, cnt_a, cnt_b,
    input  roen, ro_pair, busy, resp, resp_valid, err
  );

  modport slave (
    input  start, challenge, counter_ctrl_state, cnt_a, cnt_b,
    output roen, ro_pair, busy, resp, resp_valid, err
  );
endinterface

// File: rtl/puf_sequencer.sv
// Ring-oscillator PUF sequencer: walks NBITS oscillator pairs starting at the
// latched challenge, compares their counts and assembles the response word.
module puf_sequencer #(
  parameter int unsigned NBITS   = 8,
  parameter logic [31:0] TIMEOUT = 32'd2100000000
) (
  input  logic           clk,
  input  logic           rst,
  puf_sequencer_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARM     = 3'd1,
    S_CAPTURE = 3'd2,
    S_RELEASE = 3'd3,
    S_NEXT    = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam logic [1:0] CTRL_IDLE = 2'b00;
  localparam logic [1:0] CTRL_DONE = 2'b11;
  localparam logic [4:0] LAST_IDX  = 5'(NBITS - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [7:0]       r_challenge, w_challenge_nxt;
  logic [4:0]       r_bit_idx, w_bit_idx_nxt;
  logic [31:0]      r_wait_cnt, w_wait_cnt_nxt;
  logic             r_seen_idle, w_seen_idle_nxt;
  logic [NBITS-1:0] r_resp, w_resp_nxt;
  logic             r_err, w_err_nxt;
  logic             r_roen, w_roen_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_resp_valid, w_resp_valid_nxt;
  logic [7:0]       r_ro_pair, w_ro_pair_nxt;
  logic             w_timeout;
  logic             w_arm_ok;
  logic             w_rel_ok;
  logic             w_bit;

  // Timeout fires on the TIMEOUT-th cycle spent in a wait state; 33-bit sum avoids wrap.
  assign w_timeout = (({1'b0, r_wait_cnt} + 33'd1) >= {1'b0, TIMEOUT});
  // A done indication only counts after the controller was seen idle in this ARM visit.
  assign w_arm_ok  = r_seen_idle && (bus.counter_ctrl_state == CTRL_DONE);
  assign w_rel_ok  = (bus.counter_ctrl_state == CTRL_IDLE);
  assign w_bit     = (bus.cnt_a > bus.cnt_b);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start) w_state_nxt = S_ARM;
        else           w_state_nxt = S_IDLE;
      end
      S_ARM: begin
        if (w_arm_ok)       w_state_nxt = S_CAPTURE;
        else if (w_timeout) w_state_nxt = S_DONE;
        else                w_state_nxt = S_ARM;
      end
      S_CAPTURE: w_state_nxt = S_RELEASE;
      S_RELEASE: begin
        if (w_rel_ok)       w_state_nxt = S_NEXT;
        else if (w_timeout) w_state_nxt = S_DONE;
        else                w_state_nxt = S_RELEASE;
      end
      S_NEXT: begin
        if (r_bit_idx == LAST_IDX) w_state_nxt = S_DONE;
        else                       w_state_nxt = S_ARM;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    w_challenge_nxt = r_challenge;
    w_bit_idx_nxt   = r_bit_idx;
    w_wait_cnt_nxt  = r_wait_cnt;
    w_seen_idle_nxt = r_seen_idle;
    w_resp_nxt      = r_resp;
    w_err_nxt       = r_err;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_challenge_nxt = bus.challenge;
          w_bit_idx_nxt   = 5'd0;
          w_wait_cnt_nxt  = 32'd0;
          w_seen_idle_nxt = 1'b0;
          w_resp_nxt      = '0;
          w_err_nxt       = 1'b0;
        end else begin
          w_err_nxt       = r_err;
        end
      end
      S_ARM: begin
        w_wait_cnt_nxt = r_wait_cnt + 32'd1;
        if (bus.counter_ctrl_state == CTRL_IDLE) w_seen_idle_nxt = 1'b1;
        else                                     w_seen_idle_nxt = r_seen_idle;
        if (!w_arm_ok && w_timeout) w_err_nxt = 1'b1;
        else                        w_err_nxt = r_err;
      end
      S_CAPTURE: begin
        for (int i = 0; i < int'(NBITS); i++) begin
          if (r_bit_idx == 5'(i)) w_resp_nxt[i] = w_bit;
          else                    w_resp_nxt[i] = r_resp[i];
        end
        w_wait_cnt_nxt = 32'd0;
      end
      S_RELEASE: begin
        w_wait_cnt_nxt = r_wait_cnt + 32'd1;
        if (!w_rel_ok && w_timeout) w_err_nxt = 1'b1;
        else                        w_err_nxt = r_err;
      end
      S_NEXT: begin
        if (r_bit_idx != LAST_IDX) begin
          w_bit_idx_nxt   = r_bit_idx + 5'd1;
          w_wait_cnt_nxt  = 32'd0;
          w_seen_idle_nxt = 1'b0;
        end else begin
          w_bit_idx_nxt   = r_bit_idx;
        end
      end
      S_DONE:  w_err_nxt = r_err;
      default: w_err_nxt = r_err;
    endcase

    // Outputs are registered against the next state so they line up with it.
    w_roen_nxt       = (w_state_nxt == S_ARM) || (w_state_nxt == S_CAPTURE);
    w_busy_nxt       = (w_state_nxt != S_IDLE);
    w_resp_valid_nxt = (w_state_nxt == S_DONE);
    w_ro_pair_nxt    = w_challenge_nxt + {3'b000, w_bit_idx_nxt};
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_challenge  <= 8'd0;
      r_bit_idx    <= 5'd0;
      r_wait_cnt   <= 32'd0;
      r_seen_idle  <= 1'b0;
      r_resp       <= '0;
      r_err        <= 1'b0;
      r_roen       <= 1'b0;
      r_busy       <= 1'b0;
      r_resp_valid <= 1'b0;
      r_ro_pair    <= 8'd0;
    end else begin
      r_challenge  <= w_challenge_nxt;
      r_bit_idx    <= w_bit_idx_nxt;
      r_wait_cnt   <= w_wait_cnt_nxt;
      r_seen_idle  <= w_seen_idle_nxt;
      r_resp       <= w_resp_nxt;
      r_err        <= w_err_nxt;
      r_roen       <= w_roen_nxt;
      r_busy       <= w_busy_nxt;
      r_resp_valid <= w_resp_valid_nxt;
      r_ro_pair    <= w_ro_pair_nxt;
    end
  end

  assign bus.roen       = r_roen;
  assign bus.busy       = r_busy;
  assign bus.resp       = r_resp;
  assign bus.resp_valid = r_resp_valid;
  assign bus.err        = r_err;
  assign bus.ro_pair    = r_ro_pair;
endmodule
